// File: rtl/bip_pkg.sv
// Shared BIP definitions: byte width, program-memory geometry defaults and
// the program loader's state encoding.
package bip_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_NBITS_O = 11;
    localparam int DEF_NBITS_D = 16;
    localparam int DEF_CELDAS  = 10;

    // Encoding is shared with legacy code, so these stay plain constants.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HI    = 3'd1;
    localparam logic [2:0] ST_LO    = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

endpackage

// File: rtl/bip_program_loader.sv
// Loads a framed program (N, 2N data bytes MSB-first, XOR checksum) into BIP
// program memory and releases the CPU reset once the checksum matches.
module bip_program_loader
    import bip_pkg::*;
#(
    parameter int NBITS_O = DEF_NBITS_O,
    parameter int NBITS_D = DEF_NBITS_D,
    parameter int CELDAS  = DEF_CELDAS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_W-1:0]  i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_pm_wr,
    output logic [NBITS_O-1:0] o_pm_addr,
    output logic [NBITS_D-1:0] o_pm_data,
    output logic               o_cpu_reset,
    output logic               o_done,
    output logic               o_error
);

    logic [2:0]         state;
    logic [NBITS_O-1:0] word_count;
    logic [NBITS_O-1:0] word_idx;
    logic [NBITS_O-1:0] idx_next;
    logic [BYTE_W-1:0]  xor_acc;
    logic               pm_wr;
    logic [NBITS_O-1:0] pm_addr;
    logic [NBITS_D-1:0] pm_data;
    logic               header_bad;

    assign header_bad = (i_rx_data == '0) || (32'(i_rx_data) > 32'(CELDAS));
    assign idx_next   = word_idx + NBITS_O'(1);

    // The write strobe is registered so address and data are settled for the
    // whole pulse; the next byte is still accepted during that cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            word_count <= '0;
            word_idx   <= '0;
            xor_acc    <= '0;
            pm_wr      <= 1'b0;
            pm_addr    <= '0;
            pm_data    <= '0;
        end else begin
            pm_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (header_bad) begin
                            state <= ST_ERROR;
                        end else begin
                            word_count <= NBITS_O'(i_rx_data);
                            word_idx   <= '0;
                            xor_acc    <= '0;
                            state      <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (i_rx_valid) begin
                        pm_data[NBITS_D-1 -: BYTE_W] <= i_rx_data;
                        xor_acc <= xor_acc ^ i_rx_data;
                        state   <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (i_rx_valid) begin
                        pm_data[BYTE_W-1:0] <= i_rx_data;
                        xor_acc  <= xor_acc ^ i_rx_data;
                        pm_wr    <= 1'b1;
                        pm_addr  <= word_idx;
                        word_idx <= idx_next;
                        state    <= (idx_next == word_count) ? ST_CHECK : ST_HI;
                    end
                end
                ST_CHECK: begin
                    if (i_rx_valid) begin
                        state <= (i_rx_data == xor_acc) ? ST_RUN : ST_ERROR;
                    end
                end
                ST_RUN:   state <= ST_RUN;
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_ERROR;
            endcase
        end
    end

    assign o_pm_wr     = pm_wr;
    assign o_pm_addr   = pm_addr;
    assign o_pm_data   = pm_data;
    assign o_cpu_reset = (state != ST_RUN);
    assign o_done      = (state == ST_RUN);
    assign o_error     = (state == ST_ERROR);

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed bench for bip_program_loader: good/bad frames, length limits,
// back-to-back bytes, mid-load reset and traffic after a completed load.
module tb_bip_program_loader;

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_pm_wr;
    logic [10:0] o_pm_addr;
    logic [15:0] o_pm_data;
    logic        o_cpu_reset;
    logic        o_done;
    logic        o_error;

    int total;
    int bad;

    logic [10:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    bip_program_loader #(.NBITS_O(11), .NBITS_D(16), .CELDAS(10)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_pm_wr     (o_pm_wr),
        .o_pm_addr   (o_pm_addr),
        .o_pm_data   (o_pm_data),
        .o_cpu_reset (o_cpu_reset),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Records every cycle in which the write strobe was high.
    always @(posedge i_clk) begin
        if (o_pm_wr) begin
            wr_addr_q.push_back(o_pm_addr);
            wr_data_q.push_back(o_pm_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic do_reset();
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_gapped(input logic [7:0] b);
        send_byte(b);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (o_pm_wr !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", o_pm_wr); end
        total++; if (o_pm_addr !== 11'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", o_pm_addr); end
        total++; if (o_pm_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", o_pm_data); end
        total++; if (o_cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset: got %b want 1", o_cpu_reset); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", o_error); end
    endtask

    task automatic test_good_load();
        do_reset();
        send_gapped(8'h02);
        send_gapped(8'h08);
        send_byte(8'h01);
        total++; if (o_pm_wr !== 1'b1) begin bad++; $display("FAIL good_wr0: got %b want 1", o_pm_wr); end
        total++; if (o_pm_addr !== 11'd0) begin bad++; $display("FAIL good_addr0: got %0d want 0", o_pm_addr); end
        total++; if (o_pm_data !== 16'h0801) begin bad++; $display("FAIL good_data0: got %h want 0801", o_pm_data); end
        @(negedge i_clk);
        total++; if (o_pm_wr !== 1'b0) begin bad++; $display("FAIL good_wr0_pulse: got %b want 0", o_pm_wr); end
        send_gapped(8'h18);
        send_byte(8'h02);
        total++; if (o_pm_wr !== 1'b1) begin bad++; $display("FAIL good_wr1: got %b want 1", o_pm_wr); end
        total++; if (o_pm_addr !== 11'd1) begin bad++; $display("FAIL good_addr1: got %0d want 1", o_pm_addr); end
        total++; if (o_pm_data !== 16'h1802) begin bad++; $display("FAIL good_data1: got %h want 1802", o_pm_data); end
        @(negedge i_clk);
        total++; if (o_done !== 1'b0 || o_cpu_reset !== 1'b1) begin bad++; $display("FAIL good_pre_check: done=%b cpu_reset=%b want 0/1", o_done, o_cpu_reset); end
        send_byte(8'h13);
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL good_done: got %b want 1", o_done); end
        total++; if (o_cpu_reset !== 1'b0) begin bad++; $display("FAIL good_cpu_reset: got %b want 0", o_cpu_reset); end
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL good_error: got %b want 0", o_error); end
        @(negedge i_clk);
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL good_write_count: got %0d want 2", wr_addr_q.size()); end
    endtask

    task automatic test_post_load();
        send_gapped(8'h02);
        send_gapped(8'hFF);
        send_gapped(8'hFF);
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL post_write_count: got %0d want 2", wr_addr_q.size()); end
        total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL post_status: done=%b cpu_reset=%b want 1/0", o_done, o_cpu_reset); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send_gapped(8'h02);
        send_gapped(8'h08);
        send_gapped(8'h01);
        send_gapped(8'h18);
        send_gapped(8'h02);
        send_byte(8'h12);
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL badck_error: got %b want 1", o_error); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL badck_done: got %b want 0", o_done); end
        total++; if (o_cpu_reset !== 1'b1) begin bad++; $display("FAIL badck_cpu_reset: got %b want 1", o_cpu_reset); end
        @(negedge i_clk);
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL badck_write_count: got %0d want 2", wr_addr_q.size()); end
        send_gapped(8'h01);
        send_gapped(8'h08);
        send_gapped(8'h01);
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL badck_ignored_writes: got %0d want 2", wr_addr_q.size()); end
        total++; if (o_error !== 1'b1 || o_done !== 1'b0) begin bad++; $display("FAIL badck_sticky: error=%b done=%b want 1/0", o_error, o_done); end
    endtask

    task automatic test_length_limits();
        do_reset();
        send_byte(8'h00);
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL len_zero_error: got %b want 1", o_error); end
        do_reset();
        send_byte(8'h0B);
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL len_over_error: got %b want 1", o_error); end
        send_gapped(8'h11);
        send_gapped(8'h22);
        send_gapped(8'h33);
        total++; if (wr_addr_q.size() !== 0) begin bad++; $display("FAIL len_over_writes: got %0d want 0", wr_addr_q.size()); end
    endtask

    // Word i is {i, 0x50+i}; the XOR of all 20 bytes works out to 0x00.
    task automatic test_max_load();
        do_reset();
        send_gapped(8'h0A);
        for (int i = 0; i < 10; i++) begin
            send_gapped(8'(i));
            send_gapped(8'(8'h50 + i));
        end
        send_byte(8'h00);
        total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL max_status: done=%b cpu_reset=%b want 1/0", o_done, o_cpu_reset); end
        @(negedge i_clk);
        total++; if (wr_addr_q.size() !== 10) begin bad++; $display("FAIL max_write_count: got %0d want 10", wr_addr_q.size()); end
        for (int i = 0; i < 10 && i < wr_addr_q.size(); i++) begin
            total++;
            if (wr_addr_q[i] !== 11'(i) || wr_data_q[i] !== {8'(i), 8'(8'h50 + i)}) begin
                bad++;
                $display("FAIL max_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, {8'(i), 8'(8'h50 + i)});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame [6];
        frame = '{8'h02, 8'h08, 8'h01, 8'h18, 8'h02, 8'h13};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            i_rx_data  = frame[i];
            i_rx_valid = 1'b1;
            @(negedge i_clk);
        end
        i_rx_valid = 1'b0;
        total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL b2b_status: done=%b cpu_reset=%b want 1/0", o_done, o_cpu_reset); end
        @(negedge i_clk);
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL b2b_write_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            total++; if (wr_addr_q[0] !== 11'd0 || wr_data_q[0] !== 16'h0801) begin bad++; $display("FAIL b2b_word0: got addr=%0d data=%h want 0/0801", wr_addr_q[0], wr_data_q[0]); end
            total++; if (wr_addr_q[1] !== 11'd1 || wr_data_q[1] !== 16'h1802) begin bad++; $display("FAIL b2b_word1: got addr=%0d data=%h want 1/1802", wr_addr_q[1], wr_data_q[1]); end
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_gapped(8'h02);
        send_gapped(8'h08);
        send_byte(8'h01);
        i_reset = 1'b1;
        @(negedge i_clk);
        total++; if (o_pm_wr !== 1'b0 || o_pm_addr !== 11'd0 || o_pm_data !== 16'h0000) begin bad++; $display("FAIL midrst_port: wr=%b addr=%0d data=%h want 0/0/0000", o_pm_wr, o_pm_addr, o_pm_data); end
        total++; if (o_cpu_reset !== 1'b1 || o_done !== 1'b0 || o_error !== 1'b0) begin bad++; $display("FAIL midrst_status: cpu_reset=%b done=%b error=%b want 1/0/0", o_cpu_reset, o_done, o_error); end
        i_reset = 1'b0;
        @(negedge i_clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        send_gapped(8'h02);
        send_gapped(8'h08);
        send_gapped(8'h01);
        send_gapped(8'h18);
        send_gapped(8'h02);
        send_gapped(8'h13);
        total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL midrst_reload: done=%b cpu_reset=%b want 1/0", o_done, o_cpu_reset); end
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL midrst_write_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            total++; if (wr_addr_q[0] !== 11'd0 || wr_data_q[0] !== 16'h0801) begin bad++; $display("FAIL midrst_word0: got addr=%0d data=%h want 0/0801", wr_addr_q[0], wr_data_q[0]); end
            total++; if (wr_addr_q[1] !== 11'd1 || wr_data_q[1] !== 16'h1802) begin bad++; $display("FAIL midrst_word1: got addr=%0d data=%h want 1/1802", wr_addr_q[1], wr_data_q[1]); end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        @(negedge i_clk);
        test_reset();
        test_good_load();
        test_post_load();
        test_bad_checksum();
        test_length_limits();
        test_max_load();
        test_back_to_back();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
